// File: rtl/tt_check_pkg.sv
// rtl/tt_check_pkg.sv - shared types and constants for the truth-table response checker
//
// Purpose: the FSM state encoding, the default input width and the
//          table-depth helper used by tt_response_checker and its
//          mismatch counter.
package tt_check_pkg;

  localparam int N_IN_DEFAULT = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } tt_state_e;

  // Number of truth-table entries for an n-bit input vector.
  function automatic int depth_of(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_mismatch_counter.sv
// rtl/tt_mismatch_counter.sv - walks the captured table against golden, one entry per cycle
//
// Purpose: compare sequencing for tt_response_checker.
// Ports:
//   CK, reset          clock / asynchronous active-low reset
//   clr                clear index and results (run start)
//   cmp_en             compare the entry at the current index this cycle
//   captured, golden   tables being compared
//   cmp_hit            current entry differs (only while cmp_en)
//   cmp_last           current index is the final entry
//   mismatch_cnt       number of differing entries seen so far
//   first_fail_vec     lowest differing index
//   first_fail_valid   first_fail_vec is meaningful
module tt_mismatch_counter
  import tt_check_pkg::*;
#(
  parameter int N_IN = N_IN_DEFAULT
) (
  input  logic                        CK,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        cmp_en,
  input  logic [depth_of(N_IN)-1:0]   captured,
  input  logic [depth_of(N_IN)-1:0]   golden,
  output logic                        cmp_hit,
  output logic                        cmp_last,
  output logic [N_IN:0]               mismatch_cnt,
  output logic [N_IN-1:0]             first_fail_vec,
  output logic                        first_fail_valid
);

  localparam int DEPTH = depth_of(N_IN);

  logic [N_IN-1:0] cmp_idx_q, cmp_idx_d;
  logic [N_IN:0]   mismatch_cnt_q, mismatch_cnt_d;
  logic [N_IN-1:0] first_fail_vec_q, first_fail_vec_d;
  logic            first_fail_valid_q, first_fail_valid_d;

  always_comb begin
    cmp_hit            = cmp_en && (captured[cmp_idx_q] != golden[cmp_idx_q]);
    cmp_last           = (cmp_idx_q == N_IN'(DEPTH - 1));
    cmp_idx_d          = cmp_idx_q;
    mismatch_cnt_d     = mismatch_cnt_q;
    first_fail_vec_d   = first_fail_vec_q;
    first_fail_valid_d = first_fail_valid_q;

    if (clr) begin
      cmp_idx_d          = '0;
      mismatch_cnt_d     = '0;
      first_fail_vec_d   = '0;
      first_fail_valid_d = 1'b0;
    end else if (cmp_en) begin
      // The index wraps back to 0 after the last entry, ready for the next run.
      cmp_idx_d = cmp_idx_q + N_IN'(1);
      if (cmp_hit) begin
        // At most DEPTH increments per run, so the N_IN+1 bit count cannot wrap.
        mismatch_cnt_d = mismatch_cnt_q + (N_IN + 1)'(1);
        if (!first_fail_valid_q) begin
          first_fail_vec_d   = cmp_idx_q;
          first_fail_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      cmp_idx_q          <= '0;
      mismatch_cnt_q     <= '0;
      first_fail_vec_q   <= '0;
      first_fail_valid_q <= 1'b0;
    end else begin
      cmp_idx_q          <= cmp_idx_d;
      mismatch_cnt_q     <= mismatch_cnt_d;
      first_fail_vec_q   <= first_fail_vec_d;
      first_fail_valid_q <= first_fail_valid_d;
    end
  end

  assign mismatch_cnt     = mismatch_cnt_q;
  assign first_fail_vec   = first_fail_vec_q;
  assign first_fail_valid = first_fail_valid_q;

endmodule

// File: rtl/tt_response_checker.sv
// rtl/tt_response_checker.sv - captures an exhaustive truth-table response and checks it against golden
//
// Purpose: consumer of an in-order (vector, response) stream; builds the
//          truth-table bitmap, then compares it against a golden table latched at start.
// Ports:
//   CK, reset          clock / asynchronous active-low reset
//   start              begin a run (accepted in IDLE or DONE)
//   golden             expected table, bit k = response for vector k
//   vec_valid/vec/resp one response sample
//   busy, done, pass   run status (pass valid while done)
//   seq_err            an out-of-order vector was seen this run (sticky)
//   mismatch_cnt       differing entries, first_fail_vec/_valid lowest failing vector
//   captured           captured table
module tt_response_checker
  import tt_check_pkg::*;
#(
  parameter int N_IN = N_IN_DEFAULT
) (
  input  logic                        CK,
  input  logic                        reset,
  input  logic                        start,
  input  logic [depth_of(N_IN)-1:0]   golden,
  input  logic                        vec_valid,
  input  logic [N_IN-1:0]             vec,
  input  logic                        resp,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        seq_err,
  output logic [N_IN:0]               mismatch_cnt,
  output logic [N_IN-1:0]             first_fail_vec,
  output logic                        first_fail_valid,
  output logic [depth_of(N_IN)-1:0]   captured
);

  localparam int DEPTH = depth_of(N_IN);

  tt_state_e        state_q, state_d;
  logic [N_IN-1:0]  exp_idx_q, exp_idx_d;
  logic [DEPTH-1:0] captured_q, captured_d;
  logic [DEPTH-1:0] golden_q, golden_d;
  logic             seq_err_q, seq_err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             run_clr;
  logic             cmp_en;
  logic             cmp_hit;
  logic             cmp_last;

  always_comb begin
    state_d    = state_q;
    exp_idx_d  = exp_idx_q;
    captured_d = captured_q;
    golden_d   = golden_q;
    seq_err_d  = seq_err_q;
    pass_d     = pass_q;
    run_clr    = 1'b0;
    cmp_en     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_CAPTURE;
          golden_d   = golden;
          captured_d = '0;
          seq_err_d  = 1'b0;
          exp_idx_d  = '0;
          pass_d     = 1'b0;
          run_clr    = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (vec_valid) begin
          if (vec == exp_idx_q) begin
            captured_d[vec] = resp;
            exp_idx_d       = exp_idx_q + N_IN'(1);
            if (exp_idx_q == N_IN'(DEPTH - 1)) begin
              state_d = ST_COMPARE;
            end
          end else begin
            // Out-of-order samples are dropped; the stream must resend exp_idx.
            seq_err_d = 1'b1;
          end
        end
      end
      ST_COMPARE: begin
        cmp_en = 1'b1;
        if (cmp_last) begin
          state_d = ST_DONE;
          // mismatch_cnt_q does not yet include the final entry, so fold in cmp_hit.
          pass_d  = (mismatch_cnt == '0) && !cmp_hit && !seq_err_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_CAPTURE) || (state_d == ST_COMPARE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      exp_idx_q  <= '0;
      captured_q <= '0;
      golden_q   <= '0;
      seq_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_idx_q  <= exp_idx_d;
      captured_q <= captured_d;
      golden_q   <= golden_d;
      seq_err_q  <= seq_err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  tt_mismatch_counter #(
    .N_IN (N_IN)
  ) u_mismatch_counter (
    .CK               (CK),
    .reset            (reset),
    .clr              (run_clr),
    .cmp_en           (cmp_en),
    .captured         (captured_q),
    .golden           (golden_q),
    .cmp_hit          (cmp_hit),
    .cmp_last         (cmp_last),
    .mismatch_cnt     (mismatch_cnt),
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign seq_err  = seq_err_q;
  assign captured = captured_q;

endmodule
